// File: rtl/mem_dump_unit.sv
// Streams `count` words from a synchronous-read memory starting at `base`,
// one word per READ/CAPTURE/SEND round, and keeps a running sum of accepted words.
module mem_dump_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic [DATA_W-1:0] sum
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO = '0;
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_remaining;
  logic [DATA_W-1:0]   r_sum;
  logic [DATA_W-1:0]   r_out_data;
  logic [ADDR_W-1:0]   r_out_addr;
  logic                r_out_last;
  logic                w_handshake;

  assign w_handshake = (r_state == SEND) && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_sum       <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            // Any accepted start opens a new dump, so the sum restarts even for an empty one.
            r_sum <= '0;
            if (count == CNT_ZERO) begin
              r_state <= DONE;
            end else begin
              r_ptr       <= base;
              r_remaining <= count;
              r_state     <= READ;
            end
          end
        end
        READ: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_out_data <= mem_rdata;
          r_out_addr <= r_ptr;
          r_out_last <= (r_remaining == CNT_ONE);
          r_state    <= SEND;
        end
        SEND: begin
          if (w_handshake) begin
            r_sum       <= r_sum + r_out_data;
            r_remaining <= r_remaining - CNT_ONE;
            r_ptr       <= r_ptr + PTR_ONE;
            r_state     <= r_out_last ? DONE : READ;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Control outputs are pure state decodes; the pointer doubles as the read address.
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign mem_re    = (r_state == READ);
  assign out_valid = (r_state == SEND);
  assign mem_addr  = r_ptr;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_last  = r_out_last;
  assign sum       = r_sum;

endmodule
